// File: rtl/param_mixer_pkg.sv
// param_mixer_pkg: shared defaults and width rule for the complex mixer.
//   DEF_IWIDTH/DEF_OWIDTH/DEF_SHIFT/DEF_CNTW - default parameter values
//   fp_width(iw)                             - full-precision sum width (2*iw+1)
package param_mixer_pkg;
    localparam int DEF_IWIDTH = 8;
    localparam int DEF_OWIDTH = 17;
    localparam int DEF_SHIFT  = 0;
    localparam int DEF_CNTW   = 16;

    // A sum of two iw x iw signed products needs one bit beyond the product width.
    function automatic int fp_width(input int iw);
        return 2 * iw + 1;
    endfunction
endpackage

// File: rtl/param_complex_mixer_if.sv
// param_complex_mixer_if: sample bus into and result bus out of the complex mixer.
//   in_valid, conj, rf_i, rf_q, lo_i, lo_q - sample side, driven by the master
//   if_i, if_q, out_valid, sat            - result side, driven by the slave (mixer)
interface param_complex_mixer_if #(
    parameter int IWIDTH = param_mixer_pkg::DEF_IWIDTH,
    parameter int OWIDTH = param_mixer_pkg::DEF_OWIDTH
);
    logic                     in_valid;
    logic                     conj;
    logic signed [IWIDTH-1:0] rf_i;
    logic signed [IWIDTH-1:0] rf_q;
    logic signed [IWIDTH-1:0] lo_i;
    logic signed [IWIDTH-1:0] lo_q;
    logic signed [OWIDTH-1:0] if_i;
    logic signed [OWIDTH-1:0] if_q;
    logic                     out_valid;
    logic                     sat;

    modport master (
        output in_valid, conj, rf_i, rf_q, lo_i, lo_q,
        input  if_i, if_q, out_valid, sat
    );

    modport slave (
        input  in_valid, conj, rf_i, rf_q, lo_i, lo_q,
        output if_i, if_q, out_valid, sat
    );
endinterface

// File: rtl/mixer_round_sat.sv
// mixer_round_sat: round-half-up, arithmetic right shift and clamp of one component.
//   x    - full-precision signed input (FW bits)
//   y    - rounded, shifted, saturated output (OWIDTH bits)
//   clip - high when y was clamped to the output range
module mixer_round_sat import param_mixer_pkg::*; #(
    parameter int FW     = fp_width(DEF_IWIDTH),
    parameter int OWIDTH = DEF_OWIDTH,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic signed [FW-1:0]     x,
    output logic signed [OWIDTH-1:0] y,
    output logic                     clip
);
    // Working width leaves headroom for the rounding add and for comparing
    // against an output range that may be wider than the input.
    localparam int WW = ((FW + 1 > OWIDTH) ? FW + 1 : OWIDTH) + 1;
    localparam logic signed [WW-1:0] HALF =
        (SHIFT > 0) ? (WW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [WW-1:0] MAXV = {{(WW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] MINV = ~MAXV;

    logic signed [WW-1:0] rnd;
    logic signed [WW-1:0] shf;

    always_comb begin
        rnd  = WW'(x) + HALF;
        shf  = rnd >>> SHIFT;
        clip = (shf > MAXV) || (shf < MINV);
        y    = (shf > MAXV) ? MAXV[OWIDTH-1:0] :
               (shf < MINV) ? MINV[OWIDTH-1:0] : shf[OWIDTH-1:0];
    end
endmodule

// File: rtl/param_complex_mixer.sv
// param_complex_mixer: 3-stage complex multiply RF*LO or RF*conj(LO) with
// rounding, saturation and a saturation event counter.
//   clock, reset_n - rising-edge clock, asynchronous active-low reset
//   clk_en         - pipeline advance; all state holds while low
//   sat_clear      - synchronous clear of sat_count (qualified by clk_en)
//   sat_count      - saturating count of clipped results
//   bus            - sample inputs and registered IF results (slave side)
module param_complex_mixer import param_mixer_pkg::*; #(
    parameter int IWIDTH = DEF_IWIDTH,
    parameter int OWIDTH = DEF_OWIDTH,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int CNTW   = DEF_CNTW
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            clk_en,
    input  logic            sat_clear,
    output logic [CNTW-1:0] sat_count,
    param_complex_mixer_if.slave bus
);
    localparam int PW = 2 * IWIDTH;
    localparam int FW = fp_width(IWIDTH);

    logic signed [IWIDTH-1:0] r_i, r_q, l_i, l_q;
    logic                     c1, v1;
    logic signed [PW-1:0]     p_ii, p_qq, p_iq, p_qi;
    logic                     c2, v2;
    logic signed [FW-1:0]     f_i, f_q;
    logic signed [OWIDTH-1:0] y_i, y_q;
    logic                     k_i, k_q;
    logic                     sat_ev;

    always_comb begin
        f_i    = c2 ? FW'(p_ii) + FW'(p_qq) : FW'(p_ii) - FW'(p_qq);
        f_q    = c2 ? FW'(p_qi) - FW'(p_iq) : FW'(p_iq) + FW'(p_qi);
        sat_ev = v2 && (k_i || k_q);
    end

    mixer_round_sat #(.FW(FW), .OWIDTH(OWIDTH), .SHIFT(SHIFT)) u_rs_i (
        .x(f_i), .y(y_i), .clip(k_i)
    );

    mixer_round_sat #(.FW(FW), .OWIDTH(OWIDTH), .SHIFT(SHIFT)) u_rs_q (
        .x(f_q), .y(y_q), .clip(k_q)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {r_i, r_q, l_i, l_q, c1, v1} <= '0;
            {p_ii, p_qq, p_iq, p_qi, c2, v2} <= '0;
            bus.if_i      <= '0;
            bus.if_q      <= '0;
            bus.out_valid <= 1'b0;
            bus.sat       <= 1'b0;
            sat_count     <= '0;
        end else if (clk_en) begin
            r_i  <= bus.rf_i;
            r_q  <= bus.rf_q;
            l_i  <= bus.lo_i;
            l_q  <= bus.lo_q;
            c1   <= bus.conj;
            v1   <= bus.in_valid;
            p_ii <= PW'(r_i) * PW'(l_i);
            p_qq <= PW'(r_q) * PW'(l_q);
            p_iq <= PW'(r_i) * PW'(l_q);
            p_qi <= PW'(r_q) * PW'(l_i);
            c2   <= c1;
            v2   <= v1;
            // Results only update on valid samples so bubbles hold the last value.
            if (v2) begin
                bus.if_i <= y_i;
                bus.if_q <= y_q;
            end
            bus.out_valid <= v2;
            bus.sat       <= sat_ev;
            // A clear coinciding with a new event restarts the count at one.
            sat_count <= sat_clear ? CNTW'(sat_ev) :
                         (sat_ev && !(&sat_count)) ? sat_count + CNTW'(1) : sat_count;
        end
    end
endmodule

// File: tb/tb_param_complex_mixer.sv
// tb_param_complex_mixer: checks three mixer configurations against a sample-level model.
module tb_param_complex_mixer;
    import param_mixer_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              clk_en = 1'b0;
    logic              sat_clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              conj = 1'b0;
    logic signed [7:0] rf_i = '0, rf_q = '0, lo_i = '0, lo_q = '0;
    logic [15:0]       cnt0, cnt2;
    logic [1:0]        cnt1;

    param_complex_mixer_if #(.IWIDTH(8), .OWIDTH(17)) b0 ();
    param_complex_mixer_if #(.IWIDTH(8), .OWIDTH(8))  b1 ();
    param_complex_mixer_if #(.IWIDTH(8), .OWIDTH(9))  b2 ();

    assign b0.in_valid = in_valid; assign b0.conj = conj;
    assign b0.rf_i = rf_i; assign b0.rf_q = rf_q; assign b0.lo_i = lo_i; assign b0.lo_q = lo_q;
    assign b1.in_valid = in_valid; assign b1.conj = conj;
    assign b1.rf_i = rf_i; assign b1.rf_q = rf_q; assign b1.lo_i = lo_i; assign b1.lo_q = lo_q;
    assign b2.in_valid = in_valid; assign b2.conj = conj;
    assign b2.rf_i = rf_i; assign b2.rf_q = rf_q; assign b2.lo_i = lo_i; assign b2.lo_q = lo_q;

    param_complex_mixer #(.IWIDTH(8), .OWIDTH(17), .SHIFT(0), .CNTW(16)) dut0 (
        .clock(clock), .reset_n(reset_n), .clk_en(clk_en), .sat_clear(sat_clear),
        .sat_count(cnt0), .bus(b0)
    );
    param_complex_mixer #(.IWIDTH(8), .OWIDTH(8), .SHIFT(0), .CNTW(2)) dut1 (
        .clock(clock), .reset_n(reset_n), .clk_en(clk_en), .sat_clear(sat_clear),
        .sat_count(cnt1), .bus(b1)
    );
    param_complex_mixer #(.IWIDTH(8), .OWIDTH(9), .SHIFT(8), .CNTW(16)) dut2 (
        .clock(clock), .reset_n(reset_n), .clk_en(clk_en), .sat_clear(sat_clear),
        .sat_count(cnt2), .bus(b2)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int sh_c[3] = '{0, 0, 8};
    int ow_c[3] = '{17, 8, 9};
    int mx_c[3] = '{65535, 3, 65535};

    typedef struct {
        logic v;
        int   fi;
        int   fq;
    } cap_t;
    cap_t q[$];

    int e_i[3], e_q[3], e_cnt[3];
    bit e_ov;
    bit e_sat[3];
    int a_i[3], a_q[3], a_cnt[3], a_ov[3], a_sat[3];

    typedef struct {
        int cfg;
        int ri, rq, li, lq;
        bit c;
        int ei, eq;
        bit es;
    } tv_t;
    tv_t tbl[12];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int rsat(input int x, input int sh, input int ow, output bit c);
        int y = x;
        int mx = (1 << (ow - 1)) - 1;
        if (sh > 0) y = (y + (1 << (sh - 1))) >>> sh;
        c = (y > mx) || (y < -mx - 1);
        return (y > mx) ? mx : (y < -mx - 1) ? -mx - 1 : y;
    endfunction

    task automatic grab();
        a_i[0] = int'(b0.if_i); a_q[0] = int'(b0.if_q); a_ov[0] = int'(b0.out_valid);
        a_sat[0] = int'(b0.sat); a_cnt[0] = int'(cnt0);
        a_i[1] = int'(b1.if_i); a_q[1] = int'(b1.if_q); a_ov[1] = int'(b1.out_valid);
        a_sat[1] = int'(b1.sat); a_cnt[1] = int'(cnt1);
        a_i[2] = int'(b2.if_i); a_q[2] = int'(b2.if_q); a_ov[2] = int'(b2.out_valid);
        a_sat[2] = int'(b2.sat); a_cnt[2] = int'(cnt2);
    endtask

    task automatic check_all(input string tag);
        grab();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s cfg%0d out_valid", tag, k), a_ov[k], int'(e_ov));
            chk($sformatf("%s cfg%0d sat", tag, k), a_sat[k], int'(e_sat[k]));
            chk($sformatf("%s cfg%0d sat_count", tag, k), a_cnt[k], e_cnt[k]);
            chk($sformatf("%s cfg%0d if_i", tag, k), a_i[k], e_i[k]);
            chk($sformatf("%s cfg%0d if_q", tag, k), a_q[k], e_q[k]);
        end
    endtask

    // Each enabled edge captures one sample slot; the slot captured two
    // enabled edges earlier is what becomes visible at this edge.
    task automatic advance(input bit v, input bit c, input int ri, rq, li, lq, input bit clr);
        cap_t n;
        bit ci, cq;
        n.v  = v;
        n.fi = c ? ri * li + rq * lq : ri * li - rq * lq;
        n.fq = c ? rq * li - ri * lq : ri * lq + rq * li;
        q.push_back(n);
        if (q.size() > 3) void'(q.pop_front());
        e_ov = 1'b0;
        for (int k = 0; k < 3; k++) e_sat[k] = 1'b0;
        if (q.size() == 3 && q[0].v) begin
            e_ov = 1'b1;
            for (int k = 0; k < 3; k++) begin
                e_i[k]   = rsat(q[0].fi, sh_c[k], ow_c[k], ci);
                e_q[k]   = rsat(q[0].fq, sh_c[k], ow_c[k], cq);
                e_sat[k] = ci | cq;
            end
        end
        for (int k = 0; k < 3; k++)
            e_cnt[k] = clr ? int'(e_sat[k]) :
                       (e_sat[k] && e_cnt[k] < mx_c[k]) ? e_cnt[k] + 1 : e_cnt[k];
    endtask

    task automatic step(input bit en, input bit v, input bit c, input int ri, rq, li, lq,
                        input bit clr, input string tag);
        clk_en = en; sat_clear = clr; in_valid = v; conj = c;
        rf_i = 8'(ri); rf_q = 8'(rq); lo_i = 8'(li); lo_q = 8'(lq);
        @(posedge clock);
        if (en) advance(v, c, ri, rq, li, lq, clr);
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic bubble(input string tag);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, tag);
    endtask

    task automatic rst_pulse(input string tag);
        reset_n = 1'b0;
        #1;
        q.delete();
        e_ov = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e_i[k] = 0; e_q[k] = 0; e_cnt[k] = 0; e_sat[k] = 1'b0;
        end
        check_all(tag);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int seen;
        bit en;
        tbl[0]  = '{0, -128, -128, -128, -128, 1'b0,   0, 32768, 1'b0};
        tbl[1]  = '{0,    3,    4,    5,   -2, 1'b1,   7,    26, 1'b0};
        tbl[2]  = '{0,    3,    4,    5,   -2, 1'b0,  23,    14, 1'b0};
        tbl[3]  = '{1,  100,    0,  100,    0, 1'b0, 127,     0, 1'b1};
        tbl[4]  = '{2,    3,    0,   64,    0, 1'b0,   1,     0, 1'b0};
        tbl[5]  = '{2,   -3,    0,   64,    0, 1'b0,  -1,     0, 1'b0};
        tbl[6]  = '{1, -128, -128, -128, -128, 1'b0,   0,   127, 1'b1};
        tbl[7]  = '{2, -128, -128, -128, -128, 1'b0,   0,   128, 1'b0};
        tbl[8]  = '{1,  127,    0, -128,    0, 1'b1, -128,    0, 1'b1};
        tbl[9]  = '{0, -128,  127, -128, -128, 1'b1, 128, -32640, 1'b0};
        tbl[10] = '{2,    1,    0, -128,    0, 1'b0,   0,     0, 1'b0};
        tbl[11] = '{2,    3,    0, -128,    0, 1'b0,  -1,     0, 1'b0};

        @(negedge clock);
        rst_pulse("reset");

        foreach (tbl[t]) begin
            step(1'b1, 1'b1, tbl[t].c, tbl[t].ri, tbl[t].rq, tbl[t].li, tbl[t].lq, 1'b0, "tbl");
            bubble("tbl");
            bubble("tbl");
            chk($sformatf("tbl%0d if_i", t), a_i[tbl[t].cfg], tbl[t].ei);
            chk($sformatf("tbl%0d if_q", t), a_q[tbl[t].cfg], tbl[t].eq);
            chk($sformatf("tbl%0d sat", t), a_sat[tbl[t].cfg], int'(tbl[t].es));
        end

        rst_pulse("clr rst");
        step(1'b1, 1'b1, 1'b0, 100, 0, 100, 0, 1'b0, "clr");
        bubble("clr");
        bubble("clr");
        chk("clr sat_count before clear", a_cnt[1], 1);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, "clr");
        chk("clr sat_count after clear", a_cnt[1], 0);
        step(1'b1, 1'b1, 1'b0, 100, 0, 100, 0, 1'b0, "clrsat");
        bubble("clrsat");
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, "clrsat");
        chk("clear with same-cycle sat", a_cnt[1], 1);
        for (int j = 0; j < 5; j++) step(1'b1, 1'b1, 1'b0, -128, 0, 127, 0, 1'b0, "cntsat");
        bubble("cntsat");
        bubble("cntsat");
        chk("sat_count holds at all-ones", a_cnt[1], 3);

        rst_pulse("en rst");
        seen = 0;
        for (int j = 0; j < 18; j++) begin
            en = (j % 2 == 0);
            step(en, en && j < 12 && j != 4, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 1'b0, "clk_en");
            if (en && a_ov[0] == 1) seen++;
        end
        chk("clk_en stream valid results", seen, 5);

        rst_pulse("mid rst");
        for (int j = 0; j < 3; j++) step(1'b1, 1'b1, 1'b0, 3, 4, 5, -2, 1'b0, "mid");
        chk("mid pre-reset out_valid", a_ov[0], 1);
        rst_pulse("mid reset");
        for (int j = 0; j < 3; j++) begin
            bubble("mid post");
            chk("mid no stale out_valid", a_ov[0], 0);
        end
        step(1'b1, 1'b1, 1'b1, 3, 4, 5, -2, 1'b0, "mid");
        bubble("mid");
        chk("mid latency early", a_ov[0], 0);
        bubble("mid");
        chk("mid latency out_valid", a_ov[0], 1);
        chk("mid latency if_i", a_i[0], 7);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) rst_pulse("rand rst");
            else step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                      int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                      $urandom_range(0, 15) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/param_complex_mixer.md
PARAM_COMPLEX_MIXER -- requirements
Module: param_complex_mixer

Interface
REQ-001 SHALL have parameter IWIDTH, default 8, signed two's-complement width of each RF and LO component.
REQ-002 SHALL have parameter OWIDTH, default 17, signed width of each IF output component.
REQ-003 SHALL have parameter SHIFT, default 0, arithmetic right shift applied to the full-precision result before saturation.
REQ-004 SHALL have parameter CNTW, default 16, width of the saturation event counter.
REQ-005 clock  in  1  sole clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 clk_en  in  1  pipeline advance enable; when low, all state SHALL hold.
REQ-008 in_valid  in  1  rf/lo samples valid this cycle.
REQ-009 conj  in  1  0: IF = RF*LO; 1: IF = RF*conj(LO); sampled with the data.
REQ-010 rf_i, rf_q, lo_i, lo_q  in  IWIDTH each  signed input samples.
REQ-011 if_i, if_q  out  OWIDTH each  signed registered mixer outputs.
REQ-012 out_valid  out  1  if_i/if_q hold a new result.
REQ-013 sat  out  1  this result's component(s) were clipped; aligned with out_valid.
REQ-014 sat_count  out  CNTW  count of saturated results since reset or clear.
REQ-015 sat_clear  in  1  synchronous clear of sat_count.

Function
REQ-016 Pipeline SHALL be 3 stages: S1 registers inputs, conj and in_valid; S2 registers four IWIDTH*2-bit products; S3 registers sum/difference, rounding, shift and saturation.
REQ-017 Latency SHALL be exactly 3 clk_en-high cycles from in_valid to out_valid; throughput one sample per enabled cycle.
REQ-018 conj=0: full-precision FI = ri*li - rq*lq, FQ = ri*lq + rq*li.
REQ-019 conj=1: full-precision FI = ri*li + rq*lq, FQ = rq*li - ri*lq.
REQ-020 Full-precision width SHALL be 2*IWIDTH+1 bits, signed, with no intermediate overflow.
REQ-021 SHIFT>0: SHALL add 2^(SHIFT-1) before arithmetic right shift (round half up); SHIFT=0: no rounding.
REQ-022 Shifted value outside OWIDTH signed range SHALL clamp to +2^(OWIDTH-1)-1 or -2^(OWIDTH-1); otherwise it SHALL be sign-extended or passed unchanged.
REQ-023 sat SHALL be high when either component clamps and out_valid is high; otherwise low.
REQ-024 sat_count SHALL increment by one per out_valid cycle with sat high, saturating at all-ones (no wrap).
REQ-025 sat_clear high with clk_en high SHALL zero sat_count; if a sat event occurs in the same cycle, the count SHALL become 1.
REQ-026 Bubbles (in_valid low) SHALL propagate as out_valid low; if_i/if_q SHALL hold their last valid values during bubbles.
REQ-027 clk_en low SHALL freeze every register, including sat_count and out_valid.

Reset
REQ-028 reset_n low SHALL asynchronously clear all pipeline registers, if_i, if_q, out_valid, sat and sat_count to 0.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight samples; the first out_valid after release SHALL come 3 enabled cycles after the first post-reset in_valid.

Structure
REQ-030 Shared package param_mixer_pkg SHALL hold the default IWIDTH/OWIDTH/SHIFT constants and a round-shift-saturate function width rule (2*IWIDTH+1).
REQ-031 One sub-module, mixer_round_sat, SHALL implement REQ-021/022 per component and SHALL be instantiated twice.

Verification (defaults unless stated)
REQ-032 rf=(-128,-128), lo=(-128,-128), conj=0 -> 3 cycles later if_i=0, if_q=32768, sat=0.
REQ-033 rf=(3,4), lo=(5,-2), conj=1 -> if_i=7, if_q=26; with conj=0 -> if_i=23, if_q=14.
REQ-034 OWIDTH=8: rf=(100,0), lo=(100,0) -> if_i=127, sat=1, sat_count=1; next sat_clear -> sat_count=0.
REQ-035 SHIFT=8, OWIDTH=9: rf=(3,0), lo=(64,0) -> if_i=1; rf=(-3,0) -> if_i=-1.
REQ-036 Stream 5 samples with clk_en toggling 1,0,1,0... and one in_valid bubble -> results in order, correct latency counting enabled cycles, out_valid low for bubble.
REQ-037 reset_n pulsed low with 2 samples in flight -> outputs 0 immediately, no stale out_valid after release.
